jtag_debug_sys_pio_edge: RTL and testbench

Parametrised Avalon-MM general-purpose I/O slave for the JTAG debug system. It generalises the fixed 32-bit input-only PIO with configurable width, per-bit direction, input synchronisation, edge capture and a maskable interrupt. It sits on the debug-system Avalon interconnect as an `s1` slave, with its pins wired to board I/O or core debug signals.

---
 rtl/jtag_debug_sys_pio_pkg.sv | 19 +
 rtl/jtag_debug_sys_pio_sync.sv | 24 ++
 rtl/jtag_debug_sys_pio_edge.sv | 124 ++++++++++++
 tb/tb_jtag_debug_sys_pio_edge.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/jtag_debug_sys_pio_pkg.sv
// Shared constants for the debug-system PIO: register word addresses,
// edge-capture selection and interrupt source selection.
package jtag_debug_sys_pio_pkg;

  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_DIR      = 3'd1;
  localparam logic [2:0] ADDR_IRQMASK  = 3'd2;
  localparam logic [2:0] ADDR_EDGECAP  = 3'd3;
  localparam logic [2:0] ADDR_OUTSET   = 3'd4;
  localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;

  localparam int unsigned EDGE_RISE = 0;
  localparam int unsigned EDGE_FALL = 1;
  localparam int unsigned EDGE_ANY  = 2;

  localparam int unsigned IRQ_EDGE  = 0;
  localparam int unsigned IRQ_LEVEL = 1;

endpackage

// File: rtl/jtag_debug_sys_pio_sync.sv
// Width x depth flop chain bringing asynchronous pins into the clk domain.
module jtag_debug_sys_pio_sync #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [STAGES-1:0][WIDTH-1:0] chain_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      chain_q <= '0;
    end else begin
      chain_q <= {chain_q[STAGES-2:0], d};
    end
  end

  assign q = chain_q[STAGES-1];

endmodule

// File: rtl/jtag_debug_sys_pio_edge.sv
// Avalon-MM GPIO slave: per-bit direction, synchronised inputs, edge capture
// with write-1-to-clear, set/clear aliases and a maskable edge or level IRQ.
module jtag_debug_sys_pio_edge
  import jtag_debug_sys_pio_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter int unsigned           SYNC_STAGES = 2,
  parameter int unsigned           EDGE_TYPE   = EDGE_RISE,
  parameter int unsigned           IRQ_MODE    = IRQ_EDGE,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [2:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  input  logic [DATA_WIDTH-1:0] in_port,
  output logic [DATA_WIDTH-1:0] out_port,
  output logic [DATA_WIDTH-1:0] out_oe,
  output logic                  irq
);

  localparam logic [2:0] WarmCycles = 3'(SYNC_STAGES + 1);

  logic [DATA_WIDTH-1:0] in_sync, in_prev_q;
  logic [DATA_WIDTH-1:0] out_reg_q, out_reg_d;
  logic [DATA_WIDTH-1:0] dir_q, mask_q;
  logic [DATA_WIDTH-1:0] edgecap_q, edgecap_d;
  logic [DATA_WIDTH-1:0] wdata, rise, fall, edge_sel, edge_hit, clr, rd_word;
  logic [31:0]           readdata_q, readdata_d;
  logic [2:0]            warm_q;
  logic                  warm_done, wr, irq_q, irq_d;

  jtag_debug_sys_pio_sync #(
    .WIDTH  (DATA_WIDTH),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (in_port),
    .q       (in_sync)
  );

  assign wr        = chipselect & ~write_n;
  assign wdata     = writedata[DATA_WIDTH-1:0];
  assign warm_done = (warm_q == WarmCycles);

  always_comb begin
    rise = in_sync & ~in_prev_q;
    fall = ~in_sync & in_prev_q;
    if (EDGE_TYPE == EDGE_FALL) begin
      edge_sel = fall;
    end else if (EDGE_TYPE == EDGE_ANY) begin
      edge_sel = rise | fall;
    end else begin
      edge_sel = rise;
    end
    // Hold off capture until the chain has flushed the reset-to-pin step.
    edge_hit  = warm_done ? edge_sel : '0;
    clr       = (wr && address == ADDR_EDGECAP) ? wdata : '0;
    edgecap_d = (edgecap_q & ~clr) | edge_hit;

    out_reg_d = out_reg_q;
    if (wr) begin
      unique case (address)
        ADDR_DATA:     out_reg_d = wdata;
        ADDR_OUTSET:   out_reg_d = out_reg_q | wdata;
        ADDR_OUTCLEAR: out_reg_d = out_reg_q & ~wdata;
        default:       out_reg_d = out_reg_q;
      endcase
    end

    unique case (address)
      ADDR_DATA:    rd_word = (dir_q & out_reg_q) | (~dir_q & in_sync);
      ADDR_DIR:     rd_word = dir_q;
      ADDR_IRQMASK: rd_word = mask_q;
      ADDR_EDGECAP: rd_word = edgecap_q;
      default:      rd_word = '0;
    endcase
    readdata_d = 32'(rd_word);

    if (IRQ_MODE == IRQ_LEVEL) begin
      irq_d = |(in_sync & mask_q);
    end else begin
      irq_d = |(edgecap_q & mask_q);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_prev_q  <= '0;
      out_reg_q  <= RESET_VALUE;
      dir_q      <= '0;
      mask_q     <= '0;
      edgecap_q  <= '0;
      readdata_q <= '0;
      warm_q     <= '0;
      irq_q      <= 1'b0;
    end else begin
      in_prev_q  <= in_sync;
      out_reg_q  <= out_reg_d;
      edgecap_q  <= edgecap_d;
      readdata_q <= readdata_d;
      irq_q      <= irq_d;
      if (!warm_done) begin
        warm_q <= warm_q + 3'd1;
      end
      if (wr && address == ADDR_DIR) begin
        dir_q <= wdata;
      end
      if (wr && address == ADDR_IRQMASK) begin
        mask_q <= wdata;
      end
    end
  end

  assign readdata = readdata_q;
  assign out_port = out_reg_q;
  assign out_oe   = dir_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_jtag_debug_sys_pio_edge.sv
// Scoreboard bench: two PIO instances (rising/edge-IRQ and any-edge/level-IRQ)
// share one bus; a pin-history model predicts every output after each edge.
module tb_jtag_debug_sys_pio_edge;

  localparam int unsigned S  = 3;
  localparam logic [31:0] RV = 32'h0000_00A5;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect, write_n;
  logic [31:0] writedata, in_port;
  logic [31:0] rd_e, rd_l, op_e, op_l, oe_e, oe_l;
  logic        irq_e, irq_l;

  always #5 clk = ~clk;

  jtag_debug_sys_pio_edge #(
    .DATA_WIDTH (32), .SYNC_STAGES (S), .EDGE_TYPE (0), .IRQ_MODE (0), .RESET_VALUE (RV)
  ) u_edge (
    .clk (clk), .reset_n (reset_n), .address (address), .chipselect (chipselect),
    .write_n (write_n), .writedata (writedata), .readdata (rd_e), .in_port (in_port),
    .out_port (op_e), .out_oe (oe_e), .irq (irq_e)
  );

  jtag_debug_sys_pio_edge #(
    .DATA_WIDTH (32), .SYNC_STAGES (S), .EDGE_TYPE (2), .IRQ_MODE (1), .RESET_VALUE (RV)
  ) u_level (
    .clk (clk), .reset_n (reset_n), .address (address), .chipselect (chipselect),
    .write_n (write_n), .writedata (writedata), .readdata (rd_l), .in_port (in_port),
    .out_port (op_l), .out_oe (oe_l), .irq (irq_l)
  );

  typedef struct {
    int          e;
    logic [31:0] rd_e, rd_l, outp, oe;
    logic        irq_e, irq_l;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_x;
  int          checks = 0;
  int          errors = 0;
  int          edge_cnt = 0;

  // Model state
  logic [31:0] m_out, m_dir, m_mask, m_cap_r, m_cap_a;
  logic [31:0] pin_hist[$];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) edge_cnt <= 0;
    else          edge_cnt <= edge_cnt + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (edge %0d, t=%0t)", name, act, exp, edge_cnt,
               $time);
    end
  endtask

  // Synchronised value after edge e = pin sampled at edge e-S+1 (edges count from 1).
  function automatic logic [31:0] insync(input int e);
    int k = e - int'(S);
    if (k < 0) return 32'h0;
    return pin_hist[k];
  endfunction

  task automatic model_reset();
    m_out   = RV;
    m_dir   = '0;
    m_mask  = '0;
    m_cap_r = '0;
    m_cap_a = '0;
    pin_hist.delete();
  endtask

  // Drive one bus cycle, predict the state after the coming edge, then cross it.
  task automatic step(input logic cs, input logic wn, input logic [2:0] a,
                      input logic [31:0] wd, input logic [31:0] pin);
    exp_t        x;
    int          e;
    logic [31:0] ins, insp, clr, data_view;
    logic        wr;
    chipselect = cs;
    write_n    = wn;
    address    = a;
    writedata  = wd;
    in_port    = pin;
    e = edge_cnt + 1;
    pin_hist.push_back(pin);
    wr   = cs && !wn;
    ins  = insync(e - 1);
    insp = insync(e - 2);
    data_view = (m_dir & m_out) | (~m_dir & ins);
    x.e     = e;
    x.rd_e  = (a == 0) ? data_view : (a == 1) ? m_dir : (a == 2) ? m_mask :
              (a == 3) ? m_cap_r : 32'h0;
    x.rd_l  = (a == 3) ? m_cap_a : x.rd_e;
    x.irq_e = |(m_cap_r & m_mask);
    x.irq_l = |(ins & m_mask);
    clr = (wr && a == 3) ? wd : 32'h0;
    m_cap_r = m_cap_r & ~clr;
    m_cap_a = m_cap_a & ~clr;
    if (e > int'(S) + 1) begin
      m_cap_r = m_cap_r | (ins & ~insp);
      m_cap_a = m_cap_a | (ins ^ insp);
    end
    if (wr) begin
      case (a)
        3'd0: m_out = wd;
        3'd1: m_dir = wd;
        3'd2: m_mask = wd;
        3'd4: m_out = m_out | wd;
        3'd5: m_out = m_out & ~wd;
        default: ;
      endcase
    end
    x.outp = m_out;
    x.oe   = m_dir;
    sb.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input int n, input logic [2:0] a, input logic [31:0] pin);
    for (int i = 0; i < n; i++) step(1'b1, 1'b1, a, 32'h0, pin);
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] wd, input logic [31:0] pin);
    step(1'b1, 1'b0, a, wd, pin);
  endtask

  task automatic random_phase(input int n);
    logic [31:0] pin = $urandom;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(3) == 0) pin = $urandom;
      step(($urandom_range(3) != 0), ($urandom_range(2) != 0), 3'($urandom_range(7)),
           $urandom, pin);
    end
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_out_port"}, op_e, RV);
    chk({tag, "_out_oe"}, oe_e, 32'h0);
    chk({tag, "_readdata"}, rd_e, 32'h0);
    chk({tag, "_irq_edge"}, {31'h0, irq_e}, 32'h0);
    chk({tag, "_irq_level"}, {31'h0, irq_l}, 32'h0);
  endtask

  always @(negedge clk) begin
    if (reset_n && sb.size() > 0 && sb[0].e <= edge_cnt) begin
      mon_x = sb.pop_front();
      if (mon_x.e != edge_cnt) chk("sb_stale_edge", edge_cnt, mon_x.e);
      chk("readdata_rise", rd_e, mon_x.rd_e);
      chk("readdata_any", rd_l, mon_x.rd_l);
      chk("out_port", op_e, mon_x.outp);
      chk("out_oe", oe_e, mon_x.oe);
      chk("out_port_b", op_l, mon_x.outp);
      chk("out_oe_b", oe_l, mon_x.oe);
      chk("irq_edge", {31'h0, irq_e}, {31'h0, mon_x.irq_e});
      chk("irq_level", {31'h0, irq_l}, {31'h0, mon_x.irq_l});
    end
  end

  initial begin
    reset_n    = 1'b0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = '0;
    writedata  = '0;
    in_port    = 32'hFFFF_FFFF;
    repeat (3) @(posedge clk);
    #1;
    reset_checks("reset");
    model_reset();
    reset_n = 1'b1;

    // Pins already high through release must not be captured.
    rd(8, 3'd3, 32'hFFFF_FFFF);

    wr(3'd1, 32'h0000_FFFF, 32'hABCD_0000);
    wr(3'd0, 32'h1234_5678, 32'hABCD_0000);
    rd(S + 2, 3'd0, 32'hABCD_0000);

    wr(3'd0, 32'h0000_000F, 32'hABCD_0000);
    wr(3'd4, 32'h0000_00F0, 32'hABCD_0000);
    rd(1, 3'd0, 32'hABCD_0000);
    wr(3'd5, 32'h0000_003C, 32'hABCD_0000);
    rd(1, 3'd0, 32'hABCD_0000);
    rd(1, 3'd4, 32'hABCD_0000);
    rd(1, 3'd5, 32'hABCD_0000);
    rd(1, 3'd6, 32'hABCD_0000);

    wr(3'd2, 32'h0000_0001, 32'h0);
    rd(S + 3, 3'd3, 32'h0);
    wr(3'd3, 32'hFFFF_FFFF, 32'h0);
    rd(S + 4, 3'd3, 32'h1);
    rd(S + 4, 3'd3, 32'h0);
    wr(3'd3, 32'h0000_0001, 32'h0);
    rd(3, 3'd3, 32'h0);

    // Rising edge on bit 2 whose capture lands on the same edge as its clear.
    wr(3'd2, 32'h0000_0004, 32'h0);
    wr(3'd3, 32'hFFFF_FFFF, 32'h0);
    rd(S, 3'd3, 32'h0);
    rd(S, 3'd3, 32'h4);
    wr(3'd3, 32'h0000_0004, 32'h4);
    rd(3, 3'd3, 32'h4);

    wr(3'd2, 32'h0000_0002, 32'h0);
    rd(S + 3, 3'd0, 32'h2);
    rd(S + 3, 3'd0, 32'h0);

    random_phase(400);

    // Asynchronous reset mid-operation, away from any clock edge.
    reset_n = 1'b0;
    #1;
    sb.delete();
    reset_checks("midreset");
    @(posedge clk);
    @(posedge clk);
    #1;
    model_reset();
    reset_n = 1'b1;
    rd(S + 3, 3'd3, 32'h0000_FFFF);
    random_phase(150);

    @(negedge clk);
    #1;
    chk("sb_drained", sb.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
